// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions: return-owner encoding and data-port write-enable encoding.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_RD_I = 2'd1,
        OWN_RD_D = 2'd2
    } owner_e;

    localparam logic [3:0] WEN_READ = 4'b0000;

    function automatic logic is_write(input logic [3:0] wen);
        return wen != WEN_READ;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks consecutive denied fetch cycles.
module sat_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM with 1-cycle read latency.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mm_pause
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] w_wait_cnt;
    logic             w_starve;
    logic             w_i_gnt;
    logic             w_d_gnt;
    owner_e           r_owner;
    owner_e           w_owner_next;

    sat_counter #(
        .MAX (MAX_WAIT),
        .W   (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (i_req & ~w_i_gnt),
        .i_clr (w_i_gnt | ~i_req),
        .o_cnt (w_wait_cnt)
    );

    assign w_starve = (w_wait_cnt == CNT_W'(MAX_WAIT));

    // Data wins conflicts unless fetch has been denied MAX_WAIT cycles in a row.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!reset) begin
            if (i_req && (!d_req || w_starve)) begin
                w_i_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wen   = WEN_READ;
        mem_wdata = '0;
        if (w_i_gnt) begin
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_wen   = d_wen;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        w_owner_next = OWN_IDLE;
        if (w_i_gnt) begin
            w_owner_next = OWN_RD_I;
        end else if (w_d_gnt && !is_write(d_wen)) begin
            w_owner_next = OWN_RD_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_IDLE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // A read in flight when reset arrives is dropped rather than returned.
    assign i_rvalid = ~reset & (r_owner == OWN_RD_I);
    assign d_rvalid = ~reset & (r_owner == OWN_RD_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign mm_pause = ~reset & ((d_req & ~w_d_gnt) | (i_req & ~w_i_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: per-cycle reference model of grants/returns plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wen;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mm_pause;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_wen;

    int n_checks = 0;
    int n_errors = 0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mm_pause  (mm_pause)
    );

    // Word at index i holds 0xDEAD0000 | i until written.
    function automatic logic [31:0] init_word(input int idx);
        return 32'hDEAD0000 | 32'(idx);
    endfunction

    // RAM attached to the DUT: byte-lane writes, registered read.
    logic [31:0] ram [int];
    always @(posedge clk) begin
        int idx;
        logic [31:0] word;
        idx  = int'(mem_addr[9:2]);
        word = ram.exists(idx) ? ram[idx] : init_word(idx);
        mem_rdata <= word;
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) word[b*8 +: 8] = mem_wdata[b*8 +: 8];
        ram[idx] = word;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: data wins ties unless fetch has waited MAX_WAIT cycles;
    // a read granted in one cycle returns to that requester in the next.
    logic [31:0] ref_mem [int];
    int          m_wait     = 0;
    int          m_pend_who = 0;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_pend_data = '0;

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[9:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    always @(negedge clk) begin : cmp_proc
        logic        eg_i, eg_d, e_irv, e_drv, e_pause;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wen;
        logic [31:0] word;
        if (!done) begin
            eg_i = 1'b0;
            eg_d = 1'b0;
            if (!reset) begin
                if (i_req && d_req) begin
                    if (m_wait == MAX_WAIT) eg_i = 1'b1;
                    else                    eg_d = 1'b1;
                end else begin
                    eg_i = i_req;
                    eg_d = d_req;
                end
            end
            e_addr  = eg_i ? i_addr : (eg_d ? d_addr : 32'h0);
            e_wen   = eg_d ? d_wen : 4'h0;
            e_wdata = eg_d ? d_wdata : 32'h0;
            e_pause = !reset && ((i_req && !eg_i) || (d_req && !eg_d));
            e_irv   = !reset && (m_pend_who == 1);
            e_drv   = !reset && (m_pend_who == 2);

            check("i_gnt",     i_gnt,     eg_i);
            check("d_gnt",     d_gnt,     eg_d);
            check("mem_addr",  mem_addr,  e_addr);
            check("mem_wen",   mem_wen,   e_wen);
            check("mem_wdata", mem_wdata, e_wdata);
            check("mm_pause",  mm_pause,  e_pause);
            check("i_rvalid",  i_rvalid,  e_irv);
            check("d_rvalid",  d_rvalid,  e_drv);
            check("i_rdata",   i_rdata,   e_irv ? m_pend_data : 32'h0);
            check("d_rdata",   d_rdata,   e_drv ? m_pend_data : 32'h0);

            m_pend_who = 0;
            if (eg_i) begin
                m_pend_who  = 1;
                m_pend_data = ref_read(i_addr);
            end else if (eg_d && d_wen == 4'h0) begin
                m_pend_who  = 2;
                m_pend_data = ref_read(d_addr);
            end else if (eg_d) begin
                word = ref_read(d_addr);
                for (int b = 0; b < 4; b++)
                    if (d_wen[b]) word[b*8 +: 8] = d_wdata[b*8 +: 8];
                ref_mem[int'(d_addr[9:2])] = word;
            end

            if (reset || eg_i || !i_req) m_wait = 0;
            else if (m_wait < MAX_WAIT)  m_wait = m_wait + 1;
        end
    end

    // One cycle of stimulus: drive just after the rising edge, return just after the falling edge.
    task automatic apply(input logic rst, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd);
        @(posedge clk);
        #1;
        reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_wen = 4'hF;
        d_addr = 32'h204; d_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        check("rst_i_gnt", i_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_mem_wen", mem_wen, 4'h0);
        check("rst_pause", mm_pause, 1'b0);
        apply(1'b1, 1'b1, 32'h100, 1'b1, 4'hF, 32'h204, 32'hFFFF_FFFF);
        idle();
        check("post_rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);

        // Fetch-only stream at 0x100.
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0);
            check("fetch_gnt", i_gnt, 1'b1);
            if (k > 0) check("fetch_data", i_rdata, 32'hDEAD0040);
        end
        idle();
        check("fetch_last_rvalid", i_rvalid, 1'b1);
        check("fetch_last_data", i_rdata, 32'hDEAD0040);

        // Continuous conflict: d,d,d,i repeating, core always paused.
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
            check("starve_i_gnt", i_gnt, (k % 4) == 3);
            check("starve_d_gnt", d_gnt, (k % 4) != 3);
            check("starve_pause", mm_pause, 1'b1);
        end
        idle();

        // Byte-lane write then read back.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 4'b0100, 32'h204, 32'h00AB0000);
        check("wr_mem_wen", mem_wen, 4'b0100);
        check("wr_mem_addr", mem_addr, 32'h204);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        check("wr_no_rvalid", d_rvalid, 1'b0);
        idle();
        check("rd_after_wr", d_rdata, 32'hDEAB0081);

        // Alternating owners.
        apply(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
        check("alt_i_ret", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hDEAD0004});
        apply(1'b0, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0, 32'h0);
        check("alt_d_ret", {i_rvalid, d_rvalid, d_rdata}, {2'b01, 32'hDEAD0008});
        idle();
        check("alt_i_ret2", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hDEAD0005});

        // Reset the cycle after a data read grant drops the return.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
        check("pre_rst_d_gnt", d_gnt, 1'b1);
        apply(1'b1, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
        check("rst_drop_rvalid", d_rvalid, 1'b0);
        check("rst_gnts", {i_gnt, d_gnt, mm_pause}, 3'b000);
        idle();
        check("rst_after_rvalid", {i_rvalid, d_rvalid}, 2'b00);

        // Write vs fetch: data wins until fetch has waited three cycles.
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h300, 32'h11223344);
            check("wr_conf_d_gnt", d_gnt, k != 3);
            check("wr_conf_i_gnt", i_gnt, k == 3);
        end
        apply(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h300, 32'h0);
        check("wait_cleared_d_gnt", d_gnt, 1'b1);
        idle();
        check("wr_conf_readback", d_rdata, 32'h11223344);
        idle();

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of both requesters and the memory.
REQ-002 Parameter: MAX_WAIT, default 3, consecutive denied fetch cycles before fetch is forced to win.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-fetch read request, held until granted.
REQ-006 i_addr  input  ADDR_W  fetch address, word aligned.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  fetch read data valid.
REQ-009 i_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data-port request, held until granted.
REQ-011 d_wen  input  4  byte write enables; 0 = read, non-zero = write.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  32  write data, already lane-aligned.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  data read data valid.
REQ-016 d_rdata  output  32  data read data, raw word.
REQ-017 mem_addr  output  ADDR_W  single-port RAM address.
REQ-018 mem_wen  output  4  RAM byte write enables.
REQ-019 mem_wdata  output  32  RAM write data.
REQ-020 mem_rdata  input  32  RAM read data, 1-cycle latency after address.
REQ-021 mm_pause  output  1  core stall: a request is pending but not granted.

Function
REQ-022 Grants SHALL be combinational in the request cycle; at most one of i_gnt/d_gnt SHALL be high per cycle.
REQ-023 Default priority: data over fetch when both request.
REQ-024 Starvation counter wait_cnt (0..MAX_WAIT, saturating): +1 each cycle i_req & ~i_gnt; cleared when i_gnt or ~i_req.
REQ-025 When wait_cnt == MAX_WAIT and both request, fetch SHALL win and data is denied that cycle.
REQ-026 Single requester SHALL always be granted the same cycle.
REQ-027 Granted requester drives mem_addr; mem_wen = d_wen only on data write grant, else 0; mem_wdata = d_wdata on data grant, else 0; no grant -> mem_addr 0, mem_wen 0.
REQ-028 Return owner register: IDLE, RD_I (fetch read issued last cycle), RD_D (data read issued last cycle); next state set by this cycle's read grant, IDLE on write grant or no grant.
REQ-029 i_rvalid = (owner == RD_I); d_rvalid = (owner == RD_D); both rdata outputs = mem_rdata when their valid is high, else 0.
REQ-030 Back-to-back reads SHALL pipeline at 1 per cycle; owner of consecutive returns follows grant order exactly.
REQ-031 Writes SHALL complete in the grant cycle and produce no rvalid.
REQ-032 mm_pause = (d_req & ~d_gnt) | (i_req & ~i_gnt).

Reset
REQ-033 On reset: owner IDLE, wait_cnt 0; i_rvalid, d_rvalid 0 the next cycle, including a read in flight (its data discarded).
REQ-034 During reset, i_gnt, d_gnt, mem_wen, mm_pause SHALL be 0 regardless of requests.

Structure
REQ-035 Owner state encoding (IDLE/RD_I/RD_D) and d_wen read/write encoding SHALL live in a shared core package.
REQ-036 Single module; the starvation counter MAY be a sub-module sat_counter, nothing else.

Verification
REQ-037 Fetch only, i_addr 0x100 each cycle for 4 cycles -> i_gnt 1 each cycle, i_rvalid 1 cycles 2-5 with mem contents of 0x100.
REQ-038 Both request reads continuously, MAX_WAIT=3 -> d_gnt 3 cycles, i_gnt 4th cycle, pattern repeats; mm_pause 1 every cycle.
REQ-039 Data write d_wen 4'b0100, d_addr 0x204, d_wdata 0x00AB0000 -> mem_wen 0100 same cycle, no d_rvalid, subsequent read returns byte 0xAB at lane 2.
REQ-040 Alternating grants fetch-read 0x10, data-read 0x20, fetch-read 0x14 -> rvalids i, d, i on following cycles with correct data.
REQ-041 Reset asserted the cycle after a data read grant -> d_rvalid 0 next cycle, wait_cnt 0, all grants 0 during reset.
REQ-042 Data write and fetch simultaneous at wait_cnt 2 -> data granted, wait_cnt 3; next conflict fetch granted, wait_cnt cleared.
